// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle CPU control FSM: opcodes, states and
// the mux/ALU select values also consumed by the datapath.
package mc_ctrl_pkg;

  localparam int CTRL_STATE_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [CTRL_STATE_W-1:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MADDR = 4'd2,
    S_MRD   = 4'd3,
    S_MWB   = 4'd4,
    S_MWR   = 4'd5,
    S_REXE  = 4'd6,
    S_RWB   = 4'd7,
    S_BEQ   = 4'd8,
    S_JMP   = 4'd9,
    S_IEXE  = 4'd10,
    S_IWB   = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    PCSRC_PC4    = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_e;

  typedef enum logic [1:0] {
    SRCB_B       = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alusrcb_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the main FSM (master) and the datapath (slave).
interface mc_control_fsm_if #(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
);
  logic [OP_W-1:0]    opcode;
  logic               zero;
  logic               pc_en;
  logic [1:0]         PCSource;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               MemtoReg;
  logic               RegDst;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUOp;
  logic               illegal_op;
  logic               instr_done;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    input  opcode, zero,
    output pc_en, PCSource, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal_op,
           instr_done, state_dbg
  );

  modport slave (
    output opcode, zero,
    input  pc_en, PCSource, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal_op,
           instr_done, state_dbg
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Main control FSM of the multicycle CPU: sequences IF/ID/EX/MEM/WB and
// decodes every datapath control signal from the current state.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int OP_W    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  mc_control_fsm_if.master  bus
);

  state_e          state_q, state_d;
  logic            run_q;
  logic [OP_W-1:0] op_s;
  logic            legal_s;

  assign op_s    = bus.opcode;
  assign legal_s = op_legal(op_s);

  // run_q holds the machine idle with all outputs low until the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = S_IF;
    if (run_q) begin
      case (state_q)
        S_IF:    state_d = S_ID;
        S_ID: begin
          case (op_s)
            OP_LW, OP_SW: state_d = S_MADDR;
            OP_RTYPE:     state_d = S_REXE;
            OP_BEQ:       state_d = S_BEQ;
            OP_J:         state_d = S_JMP;
            OP_ADDI:      state_d = S_IEXE;
            default:      state_d = S_IF;
          endcase
        end
        S_MADDR: begin
          case (op_s)
            OP_LW:   state_d = S_MRD;
            OP_SW:   state_d = S_MWR;
            default: state_d = S_IF;
          endcase
        end
        S_MRD:   state_d = S_MWB;
        S_REXE:  state_d = S_RWB;
        S_IEXE:  state_d = S_IWB;
        default: state_d = S_IF;
      endcase
    end else begin
      state_d = S_IF;
    end
  end

  logic     pc_write_s, pc_write_cond_s;
  pcsrc_e   pc_source_s;
  alusrcb_e alu_src_b_s;
  aluop_e   alu_op_s;
  logic     iord_s, mem_read_s, mem_write_s, ir_write_s, mem_to_reg_s;
  logic     reg_dst_s, reg_write_s, alu_src_a_s, illegal_s, done_s;

  always_comb begin
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    pc_source_s     = PCSRC_PC4;
    alu_src_b_s     = SRCB_B;
    alu_op_s        = ALUOP_ADD;
    iord_s          = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    mem_to_reg_s    = 1'b0;
    reg_dst_s       = 1'b0;
    reg_write_s     = 1'b0;
    alu_src_a_s     = 1'b0;
    illegal_s       = 1'b0;
    done_s          = 1'b0;
    if (run_q) begin
      case (state_q)
        S_IF: begin
          mem_read_s  = 1'b1;
          ir_write_s  = 1'b1;
          alu_src_b_s = SRCB_FOUR;
          pc_write_s  = 1'b1;
        end
        S_ID: begin
          alu_src_b_s = SRCB_IMM_SH2;
          illegal_s   = ~legal_s;
          done_s      = ~legal_s;
        end
        S_MADDR, S_IEXE: begin
          alu_src_a_s = 1'b1;
          alu_src_b_s = SRCB_IMM;
        end
        S_MRD: begin
          mem_read_s = 1'b1;
          iord_s     = 1'b1;
        end
        S_MWB: begin
          reg_write_s  = 1'b1;
          mem_to_reg_s = 1'b1;
          done_s       = 1'b1;
        end
        S_MWR: begin
          mem_write_s = 1'b1;
          iord_s      = 1'b1;
          done_s      = 1'b1;
        end
        S_REXE: begin
          alu_src_a_s = 1'b1;
          alu_op_s    = ALUOP_FUNCT;
        end
        S_RWB: begin
          reg_write_s = 1'b1;
          reg_dst_s   = 1'b1;
          done_s      = 1'b1;
        end
        S_BEQ: begin
          alu_src_a_s     = 1'b1;
          alu_op_s        = ALUOP_SUB;
          pc_write_cond_s = 1'b1;
          pc_source_s     = PCSRC_BRANCH;
          done_s          = 1'b1;
        end
        S_JMP: begin
          pc_write_s  = 1'b1;
          pc_source_s = PCSRC_JUMP;
          done_s      = 1'b1;
        end
        S_IWB: begin
          reg_write_s = 1'b1;
          done_s      = 1'b1;
        end
        default: begin
          done_s = 1'b0;
        end
      endcase
    end else begin
      done_s = 1'b0;
    end
  end

  assign bus.pc_en      = pc_write_s | (pc_write_cond_s & bus.zero);
  assign bus.PCSource   = pc_source_s;
  assign bus.IorD       = iord_s;
  assign bus.MemRead    = mem_read_s;
  assign bus.MemWrite   = mem_write_s;
  assign bus.IRWrite    = ir_write_s;
  assign bus.MemtoReg   = mem_to_reg_s;
  assign bus.RegDst     = reg_dst_s;
  assign bus.RegWrite   = reg_write_s;
  assign bus.ALUSrcA    = alu_src_a_s;
  assign bus.ALUSrcB    = alu_src_b_s;
  assign bus.ALUOp      = alu_op_s;
  assign bus.illegal_op = illegal_s;
  assign bus.instr_done = done_s;
  assign bus.state_dbg  = STATE_W'(state_q);

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main control state machine for the multicycle CPU.
- Decodes the latched instruction opcode and steps through fetch, decode, execute, memory and write-back states.
- Generates every datapath control signal, including the 2-bit PCSource select consumed by the PC-source mux and the PC write enable.
- Sits between the instruction register and the datapath muxes, ALU control, register file and memory.

Parameters:
- STATE_W, 4, width of the state register and of the debug state output.
- OP_W, 6, opcode field width (instr[31:26]).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OP_W  instr[31:26] from the instruction register; valid from ID onward.
- zero  in  1  ALU zero flag.
- pc_en  out  1  PC register write enable = PCWrite | (PCWriteCond & zero).
- PCSource  out  2  00 = ALU result (PC+4), 01 = ALUOut (branch target), 10 = jump target.
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  1 = MDR to register file, 0 = ALUOut.
- RegDst  out  1  1 = rd, 0 = rt.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- illegal_op  out  1  one-cycle pulse in ID when the opcode is unsupported.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- state_dbg  out  STATE_W  current state encoding.

Behaviour:
- Moore machine: all outputs decode combinationally from the current state, except pc_en (uses zero) and illegal_op (uses opcode).
- Every output is fully specified in every state. Unlisted signals are 0; PCSource and ALUSrcB default to 00.
- Reset: rst_n low asynchronously forces state = IF. While rst_n is low, pc_en, MemRead, MemWrite, IRWrite, RegWrite, illegal_op and instr_done are forced 0; all other outputs are 0. Reset asserted mid-instruction abandons the instruction with no partial write. First IF occurs on the first rising edge after rst_n deasserts.
- States and the signals each asserts:
  - IF(0): MemRead, IRWrite, ALUSrcB=01, PCWrite, PCSource=00 -> ID.
  - ID(1): ALUSrcB=11 (branch target to ALUOut). Next by opcode:
    - lw/sw -> MADDR
    - R-type -> REXE
    - beq -> BEQ
    - j -> JMP
    - addi -> IEXE
    - anything else -> IF, with illegal_op and instr_done pulsed.
  - MADDR(2): ALUSrcA, ALUSrcB=10 -> MRD if lw, MWR if sw.
  - MRD(3): MemRead, IorD -> MWB.
  - MWB(4): RegWrite, MemtoReg, RegDst=0, instr_done -> IF.
  - MWR(5): MemWrite, IorD, instr_done -> IF.
  - REXE(6): ALUSrcA, ALUSrcB=00, ALUOp=10 -> RWB.
  - RWB(7): RegWrite, RegDst, instr_done -> IF.
  - BEQ(8): ALUSrcA, ALUOp=01, PCWriteCond, PCSource=01, instr_done -> IF.
  - JMP(9): PCWrite, PCSource=10, instr_done -> IF.
  - IEXE(10): ALUSrcA, ALUSrcB=10, ALUOp=00 -> IWB.
  - IWB(11): RegWrite, RegDst=0, MemtoReg=0, instr_done -> IF.
- Encodings 12–15 are unreachable. If entered, next state = IF with all outputs 0.
- The opcode is sampled in ID and again in MADDR. The IR is not rewritten outside IF, so the value is stable.
- Latencies in cycles: lw 5; sw, R-type, addi 4; beq, j 3.
- beq with zero=0: pc_en = 0 in BEQ and the PC keeps PC+4 written in IF.
- pc_en is never asserted outside IF, BEQ and JMP.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - opcode constants: OP_RTYPE 6'h00, OP_J 6'h02, OP_BEQ 6'h04, OP_ADDI 6'h08, OP_LW 6'h23, OP_SW 6'h2B;
  - state encodings;
  - PCSource, ALUSrcB and ALUOp encodings (also used by the datapath muxes and ALU control).
- No sub-module: a single always_ff state register plus two combinational blocks (next-state, output decode).

Test Plan:
- Reset: hold rst_n=0 while toggling clk -> state_dbg=0 and all enables 0. Release rst_n, opcode=6'h23 -> states 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4; instr_done pulses once.
- sw (6'h2B) -> states 0,1,2,5,0. MemWrite=1 and IorD=1 only in state 5; RegWrite is never 1.
- beq (6'h04):
  - zero=1 in BEQ -> pc_en=1 with PCSource=01.
  - zero=0 -> pc_en=0 in BEQ.
  - Both cases take 3 cycles.
- j (6'h02) -> pc_en=1 and PCSource=10 in state 9. R-type 6'h00 -> RegDst=1 and ALUOp=10 in states 6/7. addi 6'h08 -> ALUSrcB=10 in state 10, RegWrite in state 11.
- Illegal opcode 6'h3F -> illegal_op pulses in ID, next state IF, no RegWrite/MemWrite at any point.
- Pull rst_n low asynchronously mid-MRD and mid-RWB -> state_dbg goes to 0 without waiting for clk; RegWrite never asserts for the aborted instruction.
